// File: rtl/tdm_demux8.sv
// TDM slot demultiplexer: tracks frame alignment on a serial sample stream
// and presents each complete 8-slot frame as one registered parallel word.
module tdm_demux8 #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [8*W-1:0] dout,
  output logic           frame_valid,
  output logic           locked,
  output logic [2:0]     slot,
  output logic           sync_err
);

  localparam int unsigned SHADOW_W = 7 * W;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_slot;
  logic [2:0]            w_slot_nxt;
  logic [SHADOW_W-1:0]   r_shadow;
  logic [SHADOW_W-1:0]   w_shadow_nxt;
  logic [8*W-1:0]        r_dout;
  logic [8*W-1:0]        w_dout_nxt;
  logic                  r_frame_valid;
  logic                  w_frame_valid_nxt;
  logic                  r_sync_err;
  logic                  w_sync_err_nxt;
  logic                  r_locked;

  // State, slot counter, shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_HUNT;
      r_slot        <= 3'd0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_shadow      <= w_shadow_nxt;
      r_dout        <= w_dout_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
      r_locked      <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Next-state: judge each accepted sample against the lock state and slot.
  // Slot 7 goes straight to dout, so the next frame's slot 0 may reuse the
  // shadow on the very next cycle without corrupting the outgoing word.
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_shadow_nxt      = r_shadow;
    w_dout_nxt        = r_dout;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;

    if (din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (sof) begin
            w_shadow_nxt[W-1:0] = din;
            w_slot_nxt          = 3'd1;
            w_state_nxt         = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (r_slot == 3'd0) begin
            if (sof) begin
              w_shadow_nxt[W-1:0] = din;
              w_slot_nxt          = 3'd1;
            end else begin
              w_sync_err_nxt = 1'b1;
              w_state_nxt    = ST_HUNT;
              w_slot_nxt     = 3'd0;
            end
          end else if (sof) begin
            w_sync_err_nxt      = 1'b1;
            w_shadow_nxt[W-1:0] = din;
            w_slot_nxt          = 3'd1;
          end else if (r_slot == 3'd7) begin
            w_dout_nxt        = {din, r_shadow};
            w_frame_valid_nxt = 1'b1;
            w_slot_nxt        = 3'd0;
          end else begin
            w_shadow_nxt[int'(r_slot)*int'(W) +: W] = din;
            w_slot_nxt = 3'(r_slot + 3'd1);
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = 3'd0;
        end
      endcase
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign slot        = r_slot;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a W=1 and a W=8 instance driven in lockstep
// (the W=1 instance sees bit 0 of each W=8 sample).
module tb_tdm_demux8;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        sof;
  logic [7:0]  din8;
  logic [0:0]  din1;

  logic [63:0] dout8;
  logic        fv8, lk8, err8;
  logic [2:0]  slot8;
  logic [7:0]  dout1;
  logic        fv1, lk1, err1;
  logic [2:0]  slot1;

  int checks = 0;
  int errors = 0;

  tdm_demux8 #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .din_valid(din_valid), .sof(sof),
    .dout(dout8), .frame_valid(fv8), .locked(lk8), .slot(slot8), .sync_err(err8)
  );

  tdm_demux8 #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid), .sof(sof),
    .dout(dout1), .frame_valid(fv1), .locked(lk1), .slot(slot1), .sync_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    din8      = d;
    din1      = d[0];
    sof       = s;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    sof       = 1'b0;
    repeat (n) tick();
  endtask

  // Common status check on both instances
  task automatic chk_status(input string tag, input logic fv, input logic lk,
                            input logic [2:0] sl, input logic er);
    chk({tag, "_fv8"},   64'(fv8),   64'(fv));
    chk({tag, "_fv1"},   64'(fv1),   64'(fv));
    chk({tag, "_lk8"},   64'(lk8),   64'(lk));
    chk({tag, "_lk1"},   64'(lk1),   64'(lk));
    chk({tag, "_slot8"}, 64'(slot8), 64'(sl));
    chk({tag, "_slot1"}, 64'(slot1), 64'(sl));
    chk({tag, "_err8"},  64'(err8),  64'(er));
    chk({tag, "_err1"},  64'(err1),  64'(er));
  endtask

  task automatic chk_dout(input string tag, input logic [63:0] e8, input logic [7:0] e1);
    chk({tag, "_dout8"}, dout8, e8);
    chk({tag, "_dout1"}, 64'(dout1), 64'(e1));
  endtask

  logic [7:0] bits [8];

  initial begin
    rst = 1'b1; din_valid = 1'b0; sof = 1'b0; din8 = '0; din1 = '0;
    bits = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0};

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_status("reset", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_dout("reset", 64'h0, 8'h00);

    // Single contiguous frame
    send(bits[0], 1'b1);
    chk_status("f1_s0", 1'b0, 1'b1, 3'd1, 1'b0);
    for (int i = 1; i < 8; i++) send(bits[i], 1'b0);
    chk_status("f1_done", 1'b1, 1'b1, 3'd0, 1'b0);
    chk_dout("f1_done", 64'h0001000001010001, 8'b0100_1101);
    idle(1);
    chk_status("f1_after", 1'b0, 1'b1, 3'd0, 1'b0);
    chk_dout("f1_hold", 64'h0001000001010001, 8'b0100_1101);

    // Hunt discard after reset
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'hAA, 1'b0);
      chk_status("hunt_drop", 1'b0, 1'b0, 3'd0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      send(8'hFF, i == 0);
      chk({"hunt_err8"}, 64'(err8), 64'h0);
      chk({"hunt_err1"}, 64'(err1), 64'h0);
    end
    chk_status("hunt_done", 1'b1, 1'b1, 3'd0, 1'b0);
    chk_dout("hunt_done", 64'hFFFFFFFF_FFFFFFFF, 8'hFF);

    // Gapped input
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), i == 0);
      if (i < 7) begin
        chk("gap_fv8", 64'(fv8), 64'h0);
        idle(i % 4);
      end
    end
    chk_status("gap_done", 1'b1, 1'b1, 3'd0, 1'b0);
    chk_dout("gap_done", 64'h17161514_13121110, 8'hAA);
    idle(1);
    chk("gap_pulse", 64'(fv8), 64'h0);

    // Early sof at slot 4, back-to-back
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), i == 0);
    send(8'h30, 1'b1);
    chk_status("early", 1'b0, 1'b1, 3'd1, 1'b1);
    chk_dout("early_hold", 64'h17161514_13121110, 8'hAA);
    for (int i = 1; i < 8; i++) begin
      send(8'h30 + 8'(i), 1'b0);
      if (i < 7) chk("early_fv8", 64'(fv8), 64'h0);
    end
    chk_status("early_done", 1'b1, 1'b1, 3'd0, 1'b0);
    chk_dout("early_done", 64'h37363534_33323130, 8'hAA);

    // Missing sof at slot 0 straight after a good frame
    send(8'h55, 1'b0);
    chk_status("miss", 1'b0, 1'b0, 3'd0, 1'b1);
    chk_dout("miss_hold", 64'h37363534_33323130, 8'hAA);
    idle(1);
    chk_status("miss_after", 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset mid-frame at slot 5
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), i == 0);
    chk_status("pre_rst", 1'b0, 1'b1, 3'd5, 1'b0);
    rst = 1'b1; din_valid = 1'b1; din8 = 8'h46; din1 = 1'b0; sof = 1'b0;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    chk_status("mid_rst", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_dout("mid_rst", 64'h0, 8'h00);
    send(8'h47, 1'b0);
    send(8'h48, 1'b0);
    chk_status("post_rst", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_dout("post_rst", 64'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
